// File: rtl/accel_fifo_port.sv
// accel_fifo_port: accelerator-side endpoint of the controller put/get protocol.
// Two identical FIFOs are built from one generate body:
//   index 0 = "to" FIFO   (controller put_req -> accelerator acc_rd_req)
//   index 1 = "from" FIFO (accelerator acc_wr_req -> controller get_req)
// Each FIFO has a register array, wrapping pointers, an occupancy count and a
// registered read port with a one-cycle valid pulse per accepted pop.
module accel_fifo_port #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             put_req,
   input  logic [WIDTH-1:0] put_data,
   output logic             to_empty,
   output logic             to_full,
   input  logic             get_req,
   output logic [WIDTH-1:0] get_data,
   output logic             get_valid,
   output logic             from_empty,
   output logic             from_full,
   input  logic             acc_rd_req,
   output logic [WIDTH-1:0] acc_rd_data,
   output logic             acc_rd_valid,
   input  logic             acc_wr_req,
   input  logic [WIDTH-1:0] acc_wr_data,
   output logic             put_ovf,
   output logic             get_udf
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   // Per-FIFO control and data, indexed 0 = "to", 1 = "from".
   logic [1:0]            push;
   logic [1:0]            pop;
   logic [1:0]            empty;
   logic [1:0]            full;
   logic [1:0]            rd_valid;
   logic [1:0][WIDTH-1:0] wr_data;
   logic [1:0][WIDTH-1:0] rd_data;

   logic put_ovf_q, put_ovf_d;
   logic get_udf_q, get_udf_d;

   assign wr_data[0] = put_data;
   assign wr_data[1] = acc_wr_data;

   // Requests are gated by the registered flags only, so a full FIFO rejects a
   // push even when a pop happens in the same cycle (and likewise for empty).
   assign push[0] = enable & put_req & ~full[0];
   assign pop[0]  = acc_rd_req & ~empty[0];
   assign push[1] = acc_wr_req & ~full[1];
   assign pop[1]  = enable & get_req & ~empty[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         logic [WIDTH-1:0] mem_q [DEPTH];
         logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
         logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic [WIDTH-1:0] data_q, data_d;
         logic             valid_q, valid_d;

         // Next-state: advance pointers on accepted ops, capture popped word.
         always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            data_d   = data_q;
            valid_d  = pop[gi];
            if (push[gi]) begin
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop[gi]) begin
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
               data_d   = mem_q[rd_ptr_q];
            end
            case ({push[gi], pop[gi]})
               2'b10:   cnt_d = cnt_q + CNT_W'(1);
               2'b01:   cnt_d = cnt_q - CNT_W'(1);
               default: cnt_d = cnt_q;
            endcase
         end

         // State register with immediate clear on reset.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               cnt_q    <= '0;
               data_q   <= '0;
               valid_q  <= 1'b0;
            end else begin
               wr_ptr_q <= wr_ptr_d;
               rd_ptr_q <= rd_ptr_d;
               cnt_q    <= cnt_d;
               data_q   <= data_d;
               valid_q  <= valid_d;
            end
         end

         // Storage array: contents need no reset, only accepted pushes write.
         always_ff @(posedge clk) begin
            if (push[gi]) begin
               mem_q[wr_ptr_q] <= wr_data[gi];
            end
         end

         assign empty[gi]    = (cnt_q == '0);
         assign full[gi]     = (cnt_q == CNT_FULL);
         assign rd_data[gi]  = data_q;
         assign rd_valid[gi] = valid_q;
      end
   endgenerate

   // Sticky protocol-error flags, only armed while the controller is enabled.
   always_comb begin
      put_ovf_d = put_ovf_q | (enable & put_req & full[0]);
      get_udf_d = get_udf_q | (enable & get_req & empty[1]);
   end

   // Error flag registers, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         put_ovf_q <= 1'b0;
         get_udf_q <= 1'b0;
      end else begin
         put_ovf_q <= put_ovf_d;
         get_udf_q <= get_udf_d;
      end
   end

   assign to_empty     = empty[0];
   assign to_full      = full[0];
   assign from_empty   = empty[1];
   assign from_full    = full[1];
   assign acc_rd_data  = rd_data[0];
   assign acc_rd_valid = rd_valid[0];
   assign get_data     = rd_data[1];
   assign get_valid    = rd_valid[1];
   assign put_ovf      = put_ovf_q;
   assign get_udf      = get_udf_q;

endmodule

// File: tb/tb_accel_fifo_port.sv
// Testbench for accel_fifo_port: queue-based scoreboard per FIFO direction.
module tb_accel_fifo_port;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic             put_req = 1'b0;
   logic [WIDTH-1:0] put_data = '0;
   logic             to_empty, to_full;
   logic             get_req = 1'b0;
   logic [WIDTH-1:0] get_data;
   logic             get_valid;
   logic             from_empty, from_full;
   logic             acc_rd_req = 1'b0;
   logic [WIDTH-1:0] acc_rd_data;
   logic             acc_rd_valid;
   logic             acc_wr_req = 1'b0;
   logic [WIDTH-1:0] acc_wr_data = '0;
   logic             put_ovf, get_udf;

   accel_fifo_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .put_req      (put_req),
      .put_data     (put_data),
      .to_empty     (to_empty),
      .to_full      (to_full),
      .get_req      (get_req),
      .get_data     (get_data),
      .get_valid    (get_valid),
      .from_empty   (from_empty),
      .from_full    (from_full),
      .acc_rd_req   (acc_rd_req),
      .acc_rd_data  (acc_rd_data),
      .acc_rd_valid (acc_rd_valid),
      .acc_wr_req   (acc_wr_req),
      .acc_wr_data  (acc_wr_data),
      .put_ovf      (put_ovf),
      .get_udf      (get_udf)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_step  = 0;

   // Scoreboard state: words expected out of each FIFO, last delivered words,
   // expected sticky error flags.
   logic [WIDTH-1:0] to_sb[$];
   logic [WIDTH-1:0] from_sb[$];
   logic [WIDTH-1:0] exp_acc = '0;
   logic [WIDTH-1:0] exp_get = '0;
   logic             exp_ovf = 1'b0;
   logic             exp_udf = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, " flags"}, 64'({to_empty, to_full, from_empty, from_full}), 64'(4'b1010));
      check_val({tag, " get_data"}, 64'(get_data), 64'd0);
      check_val({tag, " get_valid"}, 64'(get_valid), 64'd0);
      check_val({tag, " acc_rd_data"}, 64'(acc_rd_data), 64'd0);
      check_val({tag, " acc_rd_valid"}, 64'(acc_rd_valid), 64'd0);
      check_val({tag, " errs"}, 64'({put_ovf, get_udf}), 64'd0);
   endtask

   // Assert reset between edges, check the clear happens before any edge,
   // hold through one edge, then release away from the edge.
   task automatic do_reset();
      enable     = 1'b0;
      put_req    = 1'b0;
      get_req    = 1'b0;
      acc_rd_req = 1'b0;
      acc_wr_req = 1'b0;
      reset      = 1'b0;
      #1;
      to_sb.delete();
      from_sb.delete();
      exp_acc = '0;
      exp_get = '0;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
      check_reset_outputs("async_reset");
      @(posedge clk);
      #1;
      check_reset_outputs("reset_held");
      #2;
      reset = 1'b1;
      $display("[TB] reset pulse done t=%0t", $time);
   endtask

   // One clock of stimulus: predict acceptance from the pre-edge scoreboard
   // occupancy, then compare every output after the edge.
   task automatic step(input logic en, input logic put, input logic [WIDTH-1:0] pdata,
                       input logic get, input logic rd, input logic wr,
                       input logic [WIDTH-1:0] wdata);
      bit to_e, to_f, fr_e, fr_f;
      bit push_to, pop_to, push_fr, pop_fr;
      to_e = (to_sb.size() == 0);
      to_f = (to_sb.size() == DEPTH);
      fr_e = (from_sb.size() == 0);
      fr_f = (from_sb.size() == DEPTH);

      enable      = en;
      put_req     = put;
      put_data    = pdata;
      get_req     = get;
      acc_rd_req  = rd;
      acc_wr_req  = wr;
      acc_wr_data = wdata;

      push_to = en && put && !to_f;
      pop_to  = rd && !to_e;
      push_fr = wr && !fr_f;
      pop_fr  = en && get && !fr_e;
      if (en && put && to_f) exp_ovf = 1'b1;
      if (en && get && fr_e) exp_udf = 1'b1;
      if (pop_to)  exp_acc = to_sb.pop_front();
      if (push_to) to_sb.push_back(pdata);
      if (pop_fr)  exp_get = from_sb.pop_front();
      if (push_fr) from_sb.push_back(wdata);

      @(posedge clk);
      #1;
      n_step++;
      check_val("acc_rd_valid", 64'(acc_rd_valid), 64'(pop_to));
      check_val("acc_rd_data", 64'(acc_rd_data), 64'(exp_acc));
      check_val("get_valid", 64'(get_valid), 64'(pop_fr));
      check_val("get_data", 64'(get_data), 64'(exp_get));
      check_val("flags", 64'({to_empty, to_full, from_empty, from_full}),
                64'({to_sb.size() == 0, to_sb.size() == DEPTH,
                     from_sb.size() == 0, from_sb.size() == DEPTH}));
      check_val("errs", 64'({put_ovf, get_udf}), 64'({exp_ovf, exp_udf}));
      $display("[TB] step %0d en=%0b put=%0b/%h get=%0b rd=%0b wr=%0b/%h -> acc=%0b/%h get=%0b/%h occ=%0d/%0d",
               n_step, en, put, pdata, get, rd, wr, wdata, acc_rd_valid, acc_rd_data,
               get_valid, get_data, to_sb.size(), from_sb.size());
   endtask

   task automatic idle();
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      do_reset();

      // Fill the "to" FIFO, overflow once, then drain in order.
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b1, 32'h9, 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
      idle();

      // Get path with an underflow on the third request.
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0002);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);

      // Full boundary: put+pop together rejects the put, delivers oldest.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 32'h100 + WIDTH'(i), 1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
      // Empty boundary: put+pop together accepts only the put.
      step(1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);

      // Wrap-around in both directions at occupancy 3.
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 32'h300 + WIDTH'(i), 1'b0, 1'b0, 1'b1, 32'h400 + WIDTH'(i));
      for (int i = 3; i < 23; i++)
         step(1'b1, 1'b1, $urandom, 1'b1, 1'b1, 1'b1, $urandom);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0);

      // Enable gating: full "to", empty "from", requests ignored with no errors.
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 32'h500 + WIDTH'(i), 1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hBAD, 1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);

      // Mid-operation reset with 5 words queued, then a clean round trip.
      do_reset();
      step(1'b1, 1'b1, 32'h7, 1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
